// File: rtl/vita_rx_sample_framer.sv
// RX sample framer: packs strobed 32-bit IQ samples into VITA-49 IF data packets
// on a 36-bit {2'b0, EOF, SOF, word} stream, buffering samples and packet descriptors.
module vita_rx_sample_framer #(
  parameter int BASE     = 0,
  parameter int FIFOSIZE = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic [63:0] vita_time,
  input  logic [31:0] sample,
  input  logic        strobe,
  input  logic        run,
  output logic [35:0] o_tdata,
  output logic        o_tvalid,
  input  logic        o_tready,
  output logic        overflow,
  output logic [15:0] ovf_count
);

  localparam int unsigned DEPTH   = 1 << FIFOSIZE;
  localparam int unsigned SPP_MAX = (DEPTH < 65531) ? DEPTH : 65531;
  localparam logic [7:0]  ADDR_SPP = 8'(BASE);
  localparam logic [7:0]  ADDR_SID = 8'(BASE + 1);
  localparam logic [7:0]  ADDR_CTL = 8'(BASE + 2);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_SID, S_TSH, S_TSL, S_PAY} state_t;

  // ---------------- settings ----------------
  logic [15:0] r_spp;
  logic [31:0] r_sid;
  logic        w_clear;
  logic        w_flush;
  logic [15:0] w_spp_eff;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_spp <= 16'd16;
      r_sid <= '0;
    end else if (set_stb) begin
      if (set_addr == ADDR_SPP) r_spp <= set_data[15:0];
      if (set_addr == ADDR_SID) r_sid <= set_data;
    end
  end

  // Clear acts like reset on the datapath but leaves the settings alone.
  assign w_clear = set_stb && (set_addr == ADDR_CTL) && set_data[0];
  assign w_flush = reset || w_clear;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_spp_eff = r_spp;
    if (r_spp == 16'd0)             w_spp_eff = 16'd1;
    else if (32'(r_spp) > SPP_MAX)  w_spp_eff = 16'(SPP_MAX);
  end

  // ---------------- input framing ----------------
  logic [15:0] r_cnt;
  logic [15:0] r_spp_l;
  logic [63:0] r_t0;
  logic        r_run_d;
  logic        r_overflow;
  logic [15:0] r_ovf_count;

  logic        w_accept, w_first, w_drop, w_push;
  logic        w_close_full, w_close_run, w_close;
  logic [15:0] w_cnt_inc, w_len_lim, w_desc_len;
  logic [63:0] w_desc_t0;
  logic        w_sfifo_full, w_desc_full, w_desc_empty;

  assign w_accept     = strobe && run;
  assign w_first      = (r_cnt == 16'd0);
  assign w_drop       = w_accept && ((w_first && w_desc_full) || w_sfifo_full);
  assign w_push       = w_accept && !w_drop;
  assign w_cnt_inc    = r_cnt + 16'd1;
  assign w_len_lim    = w_first ? w_spp_eff : r_spp_l;
  assign w_close_full = w_push && (w_cnt_inc == w_len_lim);
  assign w_close_run  = r_run_d && !run && (r_cnt != 16'd0);
  assign w_close      = w_close_full || w_close_run;
  assign w_desc_len   = w_close_full ? w_cnt_inc : r_cnt;
  // A one-sample packet closes in the cycle that also captures its timestamp.
  assign w_desc_t0    = (w_push && w_first) ? vita_time : r_t0;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_cnt       <= '0;
      r_spp_l     <= 16'd1;
      r_t0        <= '0;
      r_run_d     <= 1'b0;
      r_overflow  <= 1'b0;
      r_ovf_count <= '0;
    end else begin
      r_run_d    <= run;
      r_overflow <= w_drop;
      if (w_drop && (r_ovf_count != 16'hFFFF)) r_ovf_count <= r_ovf_count + 16'd1;
      if (w_push && w_first) begin
        r_t0    <= vita_time;
        r_spp_l <= w_spp_eff;
      end
      if (w_close)     r_cnt <= '0;
      else if (w_push) r_cnt <= w_cnt_inc;
    end
  end

  // ---------------- sample FIFO ----------------
  logic [31:0]       r_smem [DEPTH];
  logic [FIFOSIZE:0] r_swr, r_srd;
  logic [31:0]       w_shead;
  logic              w_spop;

  assign w_sfifo_full = (r_swr[FIFOSIZE] != r_srd[FIFOSIZE]) &&
                        (r_swr[FIFOSIZE-1:0] == r_srd[FIFOSIZE-1:0]);
  assign w_shead      = r_smem[r_srd[FIFOSIZE-1:0]];

  // NOTE: storage arrays are not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_smem[r_swr[FIFOSIZE-1:0]] <= sample;
  end

  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_swr <= '0;
      r_srd <= '0;
    end else begin
      if (w_push) r_swr <= r_swr + 1'b1;
      if (w_spop) r_srd <= r_srd + 1'b1;
    end
  end

  // ---------------- descriptor FIFO: {len, t0}, depth 4 ----------------
  logic [79:0] r_dmem [4];
  logic [2:0]  r_dwr, r_drd;
  logic [15:0] w_dhead_len;
  logic [63:0] w_dhead_t0;
  logic        w_dpop;

  assign w_desc_full  = (r_dwr[2] != r_drd[2]) && (r_dwr[1:0] == r_drd[1:0]);
  assign w_desc_empty = (r_dwr == r_drd);
  assign {w_dhead_len, w_dhead_t0} = r_dmem[r_drd[1:0]];

  always_ff @(posedge clk) begin
    if (w_close) r_dmem[r_dwr[1:0]] <= {w_desc_len, w_desc_t0};
  end

  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_dwr <= '0;
      r_drd <= '0;
    end else begin
      if (w_close) r_dwr <= r_dwr + 3'd1;
      if (w_dpop)  r_drd <= r_drd + 3'd1;
    end
  end

  // ---------------- output FSM ----------------
  state_t      r_state;
  logic [35:0] r_tdata;
  logic        r_tvalid;
  logic [15:0] r_len;
  logic [15:0] r_left;
  logic [63:0] r_ot0;
  logic [3:0]  r_seq;
  logic        w_adv;

  assign w_adv  = r_tvalid && o_tready;
  // r_left counts payload words still to be loaded after the one on the bus.
  assign w_spop = w_adv && ((r_state == S_TSL) || ((r_state == S_PAY) && (r_left != 16'd0)));
  assign w_dpop = w_adv && (r_state == S_PAY) && (r_left == 16'd0);

  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_state  <= S_IDLE;
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_len    <= '0;
      r_left   <= '0;
      r_ot0    <= '0;
      r_seq    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (!w_desc_empty) begin
          r_len    <= w_dhead_len;
          r_ot0    <= w_dhead_t0;
          r_tdata  <= {2'b00, 1'b0, 1'b1, 4'h1, 4'h0, 2'b00, 2'b01, r_seq,
                       w_dhead_len + 16'd4};
          r_tvalid <= 1'b1;
          r_state  <= S_HDR;
        end
        S_HDR: if (w_adv) begin
          r_tdata <= {4'h0, r_sid};
          r_state <= S_SID;
        end
        S_SID: if (w_adv) begin
          r_tdata <= {4'h0, r_ot0[63:32]};
          r_state <= S_TSH;
        end
        S_TSH: if (w_adv) begin
          r_tdata <= {4'h0, r_ot0[31:0]};
          r_state <= S_TSL;
        end
        S_TSL: if (w_adv) begin
          r_tdata <= {2'b00, (r_len == 16'd1), 1'b0, w_shead};
          r_left  <= r_len - 16'd1;
          r_state <= S_PAY;
        end
        S_PAY: if (w_adv) begin
          if (r_left == 16'd0) begin
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
            r_seq    <= r_seq + 4'd1;
            r_state  <= S_IDLE;
          end else begin
            r_tdata <= {2'b00, (r_left == 16'd1), 1'b0, w_shead};
            r_left  <= r_left - 16'd1;
          end
        end
        default: begin
          r_tvalid <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign o_tdata   = r_tdata;
  assign o_tvalid  = r_tvalid;
  assign overflow  = r_overflow;
  assign ovf_count = r_ovf_count;

endmodule

// File: tb/tb_vita_rx_sample_framer.sv
// Scoreboard bench for vita_rx_sample_framer: a packet model queues expected words as
// samples are driven; a negedge monitor pops them on every output handshake.
module tb_vita_rx_sample_framer;

  localparam int FS    = 4;
  localparam int DEPTH = 1 << FS;
  localparam int LIM   = (DEPTH < 65531) ? DEPTH : 65531;

  logic        clk = 1'b0;
  logic        reset, set_stb, strobe, run, o_tready;
  logic [7:0]  set_addr;
  logic [31:0] set_data, sample;
  logic [63:0] vita_time;
  logic [35:0] o_tdata;
  logic        o_tvalid, overflow;
  logic [15:0] ovf_count;

  always #5 clk = ~clk;

  vita_rx_sample_framer #(.BASE(0), .FIFOSIZE(FS)) dut (
    .clk(clk), .reset(reset),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .vita_time(vita_time), .sample(sample), .strobe(strobe), .run(run),
    .o_tdata(o_tdata), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .overflow(overflow), .ovf_count(ovf_count)
  );

  typedef struct {
    logic [35:0] w;
    bit          pay;
    bit          last;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_pay[$];
  int          m_cnt = 0, m_spp_l = 1, m_spp = 16, m_fifo = 0, m_desc = 0, m_drops = 0;
  logic [63:0] m_t0 = '0;
  logic [31:0] m_sid = '0;
  logic [3:0]  m_seq = '0;
  int          total = 0, bad = 0, ovf_pulses = 0;
  bit          mon_en = 0, rand_rdy = 0, prev_stall = 0;
  logic [35:0] prev_data = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Header layout: type=1, TSI=0, TSF=1, packet count in [19:16], size in [15:0].
  task automatic model_close();
    exp_t e;
    int   len;
    len    = m_cnt;
    e.pay  = 0;
    e.last = 0;
    e.w = {2'b00, 1'b0, 1'b1, 4'h1, 4'h0, 2'b00, 2'b01, m_seq, 16'(len + 4)};
    exp_q.push_back(e);
    e.w = {4'h0, m_sid};        exp_q.push_back(e);
    e.w = {4'h0, m_t0[63:32]};  exp_q.push_back(e);
    e.w = {4'h0, m_t0[31:0]};   exp_q.push_back(e);
    for (int i = 0; i < len; i++) begin
      e.w    = {2'b00, (i == len - 1), 1'b0, m_pay[i]};
      e.pay  = 1;
      e.last = (i == len - 1);
      exp_q.push_back(e);
    end
    m_pay.delete();
    m_cnt = 0;
    m_seq = m_seq + 4'd1;
    m_desc++;
  endtask

  task automatic model_sample(input logic [31:0] s, input logic [63:0] t);
    int lim;
    lim = (m_spp == 0) ? 1 : ((m_spp > LIM) ? LIM : m_spp);
    if ((m_cnt == 0 && m_desc >= 4) || m_fifo >= DEPTH) begin
      m_drops++;
    end else begin
      if (m_cnt == 0) begin
        m_t0    = t;
        m_spp_l = lim;
      end
      m_pay.push_back(s);
      m_fifo++;
      m_cnt++;
      if (m_cnt == m_spp_l) model_close();
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_pay.delete();
    m_cnt  = 0;
    m_seq  = '0;
    m_fifo = 0;
    m_desc = 0;
    m_drops = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) o_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    set_stb = 1; set_addr = a; set_data = d;
    tick();
    set_stb = 0;
    if (a == 8'd0) m_spp = int'(d[15:0]);
    if (a == 8'd1) m_sid = d;
    if (a == 8'd2 && d[0]) model_clear();
  endtask

  task automatic send(input logic [31:0] s, input logic [63:0] t);
    sample = s; vita_time = t; strobe = 1;
    if (run) model_sample(s, t);
    tick();
    strobe = 0;
  endtask

  task automatic stop_run();
    run = 0;
    if (m_cnt > 0) model_close();
    tick();
    run = 1;
    tick();
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      tick();
      n++;
    end
    check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    repeat (3) tick();
  endtask

  // Output monitor: samples away from the rising edge.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en) begin
      if (prev_stall) begin
        check("stall_valid", 64'(o_tvalid), 64'd1);
        check("stall_data", 64'(o_tdata), 64'(prev_data));
      end
      if (overflow) ovf_pulses++;
      if (o_tvalid && o_tready) begin
        check("word_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("word", 64'(o_tdata), 64'(e.w));
          if (e.pay)  m_fifo--;
          if (e.last) m_desc--;
        end
      end
      prev_stall = o_tvalid && !o_tready;
      prev_data  = o_tdata;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap_p, snap_d;
    reset = 1; set_stb = 0; set_addr = '0; set_data = '0;
    vita_time = '0; sample = '0; strobe = 0; run = 0; o_tready = 1;
    repeat (3) @(posedge clk);
    #1;
    reset = 0;
    check("rst_tvalid", 64'(o_tvalid), 64'd0);
    check("rst_tdata", 64'(o_tdata), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_ovf_count", 64'(ovf_count), 64'd0);
    mon_en = 1;
    run = 1;
    tick();

    // Reset settings: spp=16, sid=0.
    for (int i = 0; i < 16; i++) send(32'h0BAD_0000 + i, 64'h10 + i);
    drain("dflt");
    wr(8'd2, 32'd1);

    // Test 1: spp=4, two packets, times 0x100 / 0x104.
    wr(8'd1, 32'hA5A5_0001);
    wr(8'd0, 32'd4);
    for (int i = 0; i < 8; i++) send(32'(i + 1), 64'h100 + i);
    drain("t1");

    // Test 2: run falling edge closes a short packet.
    wr(8'd0, 32'd10);
    for (int i = 0; i < 3; i++) send(32'h2000 + i, 64'h2000 + i);
    stop_run();
    drain("t2");

    // Test 3: sample FIFO fills while stalled.
    wr(8'd0, 32'd16);
    o_tready = 0;
    snap_p = ovf_pulses;
    snap_d = m_drops;
    for (int i = 0; i < 20; i++) send(32'h3000 + i, 64'h3000 + i);
    tick();
    check("t3_ovf_count", 64'(ovf_count), 64'(m_drops));
    check("t3_drops", 64'(m_drops - snap_d), 64'd4);
    check("t3_ovf_pulses", 64'(ovf_pulses - snap_p), 64'(m_drops - snap_d));
    o_tready = 1;
    drain("t3");

    // Descriptor FIFO full: spp=1, stalled, 6 samples -> 4 packets, 2 drops.
    wr(8'd0, 32'd1);
    o_tready = 0;
    snap_p = ovf_pulses;
    snap_d = m_drops;
    for (int i = 0; i < 6; i++) send(32'h4000 + i, 64'h4000 + i);
    tick();
    check("dfull_ovf_count", 64'(ovf_count), 64'(m_drops));
    check("dfull_drops", 64'(m_drops - snap_d), 64'd2);
    check("dfull_ovf_pulses", 64'(ovf_pulses - snap_p), 64'(m_drops - snap_d));
    o_tready = 1;
    drain("dfull");

    // spp above the FIFO limit clamps.
    wr(8'd0, 32'd100);
    for (int i = 0; i < LIM; i++) send(32'h5000 + i, 64'h5000 + i);
    drain("clamp");

    // Test 5: clear mid-packet.
    wr(8'd0, 32'd4);
    send(32'h6000, 64'h6000);
    send(32'h6001, 64'h6001);
    wr(8'd2, 32'd1);
    repeat (10) tick();
    check("t5_no_output", 64'(o_tvalid), 64'd0);
    check("t5_ovf_cleared", 64'(ovf_count), 64'(m_drops));
    for (int i = 0; i < 4; i++) send(32'h6100 + i, 64'h6100 + i);
    drain("t5");

    // Test 4: random backpressure, spp=2, 40 packets, seq wraps.
    wr(8'd2, 32'd1);
    wr(8'd0, 32'd2);
    rand_rdy = 1;
    for (int p = 0; p < 40; p++) begin
      int n;
      repeat ($urandom_range(0, 3)) tick();
      for (int k = 0; k < 2; k++) send($urandom, {$urandom, $urandom});
      n = 0;
      while (exp_q.size() > 6 && n < 500) begin
        tick();
        n++;
      end
      check("t4_backlog", 64'(exp_q.size() <= 6), 64'd1);
    end
    rand_rdy = 0;
    o_tready = 1;
    drain("t4");
    check("t4_ovf_count", 64'(ovf_count), 64'(m_drops));

    // Test 6: spp=0 behaves as 1.
    wr(8'd0, 32'd0);
    send(32'h7000, 64'h7000);
    send(32'h7001, 64'h7001);
    drain("t6");

    check("final_queue", 64'(exp_q.size()), 64'd0);
    check("final_ovf_count", 64'(ovf_count), 64'(m_drops));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
